sqrt_scheduler: RTL and testbench

Shares one integer_sqrt core between NUM_REQ requesters using round-robin arbitration. Per job, the block latches the winning operand and restarts the core via its stall input. It then waits for core ready and returns quotient, remainder and requester id on a single valid/ready response channel. It sits between the pipeline stages that need square roots and the single multi-cycle core instance.

---
 rtl/sqrt_scheduler_pkg.sv | 23 ++
 rtl/integer_sqrt.sv | 66 ++++++
 rtl/sqrt_scheduler_rr_arbiter.sv | 46 ++++
 rtl/sqrt_scheduler.sv | 163 ++++++++++++++++
 tb/tb_sqrt_scheduler.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/sqrt_scheduler_pkg.sv
// Shared definitions for the square-root scheduler: FSM state encoding,
// watchdog limit and legal-operand width helpers.
package sqrt_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Operands must fit in this many bits: one bit-pair consumed at restart
  // plus one bit-pair per core iteration.
  function automatic int legal_bits(input int cycles);
    return 2 * (cycles + 1);
  endfunction

  // WAIT cycles allowed before the job is abandoned with an error.
  function automatic int wd_limit(input int cycles);
    return cycles + 4;
  endfunction

endpackage

// File: rtl/integer_sqrt.sv
// Multi-cycle restoring integer square root. A stall cycle restarts the core
// and consumes the top bit-pair of data_in; each following cycle consumes one
// more pair. ready rises after CYCLES further cycles and holds until the next
// stall. Operands must fit in 2*(CYCLES+1) bits.
module integer_sqrt #(
  parameter int WIDTH  = 32,
  parameter int CYCLES = 14
) (
  input  logic             clk,
  input  logic             stall,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int N     = 2 * (CYCLES + 1);
  localparam int CNT_W = $clog2(CYCLES + 1);

  logic [WIDTH-1:0] op;
  logic [WIDTH-1:0] root;
  logic [WIDTH-1:0] rem;
  logic [CNT_W-1:0] count;

  logic [1:0]       first_pair;
  logic             first_root;
  logic [1:0]       first_rem;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-1:0] trial;
  logic             fits;

  // One restoring step: bring down the next pair, try subtracting 4*root+1.
  always_comb begin
    first_pair = data_in[N-1 -: 2];
    first_root = (first_pair != 2'b00);
    first_rem  = first_pair - {1'b0, first_root};
    rem_sh     = {rem[WIDTH-3:0], op[N-1 -: 2]};
    trial      = {root[WIDTH-3:0], 2'b01};
    fits       = (rem_sh >= trial);
  end

  // Restart on stall, otherwise iterate until the count is exhausted.
  always_ff @(posedge clk) begin
    if (stall) begin
      op    <= data_in << 2;
      root  <= WIDTH'(first_root);
      rem   <= WIDTH'(first_rem);
      count <= '0;
    end else if (count != CNT_W'(CYCLES)) begin
      op    <= op << 2;
      count <= count + CNT_W'(1);
      if (fits) begin
        rem  <= rem_sh - trial;
        root <= {root[WIDTH-2:0], 1'b1};
      end else begin
        rem  <= rem_sh;
        root <= {root[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign ready     = (count == CNT_W'(CYCLES));
  assign quotient  = root;
  assign remainder = rem;

endmodule

// File: rtl/sqrt_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational grant searching upward from ptr with
// wrap-around, and a registered ptr that moves past the winner on accept.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               stall,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               accept,
  output logic [ID_W-1:0]    grant,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic               any_valid
);

  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] shifted;
  int                 idx;

  // Scan from the farthest slot back to ptr so the closest valid one wins.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    shifted   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx     = (int'(ptr) + k) % NUM_REQ;
      shifted = req_valid >> idx;
      if (shifted[0]) begin
        grant     = ID_W'(idx);
        any_valid = 1'b1;
      end
    end
    grant_oh = any_valid ? (NUM_REQ'(1) << grant) : '0;
  end

  // Pointer moves to the slot just after the accepted requester.
  always_ff @(posedge clk) begin
    if (stall) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
    end
  end

endmodule

// File: rtl/sqrt_scheduler.sv
// Shares one integer_sqrt core among NUM_REQ requesters. A job is accepted
// from the round-robin winner, the core is restarted for one CLEAR cycle,
// the FSM waits for core ready (bounded by a watchdog) and the result is
// offered on one response channel.
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high; valid never depends on ready, and a raised valid holds its
// payload stable until that transfer.
module sqrt_scheduler
  import sqrt_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int CYCLES  = 14,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     stall,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_quotient,
  output logic [WIDTH-1:0]         rsp_remainder,
  output logic                     rsp_err,
  output logic                     busy
);

  localparam int LB   = legal_bits(CYCLES);
  localparam int WDL  = wd_limit(CYCLES);
  localparam int WD_W = $clog2(WDL + 1);

  state_t state, state_nx;

  logic [WIDTH-1:0]   op_q;
  logic [ID_W-1:0]    id_q;
  logic [WD_W-1:0]    wd;
  logic [WD_W-1:0]    wd_inc;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH-1:0]   r_q;
  logic               err_q;

  logic [ID_W-1:0]    grant;
  logic [NUM_REQ-1:0] grant_oh;
  logic               any_valid;
  logic               accept;
  logic [WIDTH-1:0]   sel_data;
  logic               sel_oor;
  logic               wd_expire;

  logic               core_stall;
  logic               core_ready;
  logic [WIDTH-1:0]   core_q;
  logic [WIDTH-1:0]   core_r;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk       (clk),
    .stall     (stall),
    .req_valid (req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_oh  (grant_oh),
    .any_valid (any_valid)
  );

  integer_sqrt #(
    .WIDTH  (WIDTH),
    .CYCLES (CYCLES)
  ) u_core (
    .clk       (clk),
    .stall     (core_stall),
    .data_in   (op_q),
    .ready     (core_ready),
    .quotient  (core_q),
    .remainder (core_r)
  );

  assign sel_data = req_data[grant*WIDTH +: WIDTH];

  generate
    if (LB >= WIDTH) begin : g_all_legal
      assign sel_oor = 1'b0;
    end else begin : g_range_check
      assign sel_oor = |sel_data[WIDTH-1:LB];
    end
  endgenerate

  assign accept     = (state == S_IDLE) && any_valid && !stall;
  assign req_ready  = accept ? grant_oh : '0;
  assign core_stall = stall || (state == S_CLEAR);
  assign wd_inc     = wd + WD_W'(1);
  assign wd_expire  = (wd_inc == WD_W'(WDL));

  assign rsp_valid     = (state == S_RESP);
  assign rsp_id        = id_q;
  assign rsp_quotient  = q_q;
  assign rsp_remainder = r_q;
  assign rsp_err       = err_q;
  assign busy          = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (stall) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state selection.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = sel_oor ? S_RESP : S_CLEAR;
      S_CLEAR: state_nx = S_WAIT;
      S_WAIT:  if (core_ready || wd_expire) state_nx = S_RESP;
      S_RESP:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Job operand/id latch, watchdog and response payload registers.
  always_ff @(posedge clk) begin
    if (stall) begin
      op_q  <= '0;
      id_q  <= '0;
      wd    <= '0;
      q_q   <= '0;
      r_q   <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q <= sel_data;
            id_q <= grant;
            if (sel_oor) begin
              q_q   <= '0;
              r_q   <= '0;
              err_q <= 1'b1;
            end
          end
        end
        S_CLEAR: wd <= '0;
        S_WAIT: begin
          wd <= wd_inc;
          if (core_ready) begin
            q_q   <= core_q;
            r_q   <= core_r;
            err_q <= 1'b0;
          end else if (wd_expire) begin
            q_q   <= '0;
            r_q   <= '0;
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_scheduler.sv
// Directed-plus-random bench for sqrt_scheduler with a behavioural square
// root model and an expected-response queue.
module tb_sqrt_scheduler;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int CYCLES  = 14;
  localparam int ID_W    = 2;
  localparam int LAT     = CYCLES + 3;
  localparam int EW      = ID_W + 1 + 2 * WIDTH;
  localparam int CW      = 80;

  logic                     clk;
  logic                     stall;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_quotient;
  logic [WIDTH-1:0]         rsp_remainder;
  logic                     rsp_err;
  logic                     busy;

  int n_vec;
  int n_err;
  int cyc;
  logic [EW-1:0] exp_q[$];

  sqrt_scheduler #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .CYCLES  (CYCLES),
    .ID_W    (ID_W)
  ) dut (
    .clk           (clk),
    .stall         (stall),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_data      (req_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_err       (rsp_err),
    .busy          (busy)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something hangs.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference: out-of-range operands report an error, else floor sqrt.
  function automatic logic [EW-1:0] model(input int id, input logic [WIDTH-1:0] x);
    longint unsigned xv, q, t;
    xv = 64'(x);
    if (xv >= 64'h4000_0000) return {ID_W'(id), 1'b1, 64'd0};
    q = 0;
    for (int b = 15; b >= 0; b--) begin
      t = q | (64'd1 << b);
      if (t * t <= xv) q = t;
    end
    return {ID_W'(id), 1'b0, 32'(q), 32'(xv - q * q)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int id, input logic [WIDTH-1:0] x);
    req_data[id*WIDTH +: WIDTH] = x;
    req_valid[id] = 1'b1;
  endtask

  // Wait for requester id to be offered ready, record that cycle, accept.
  task automatic wait_grant(input int id, input bit hold, output int t);
    int waited;
    waited = 0;
    #1;
    while (!req_ready[id] && waited < 100) begin
      step();
      waited++;
    end
    t = cyc;
    check("grant_onehot", CW'(req_ready), CW'(4'b0001 << id));
    exp_q.push_back(model(id, req_data[id*WIDTH +: WIDTH]));
    step();
    if (!hold) req_valid[id] = 1'b0;
  endtask

  // Wait for the response, check latency and payload, handshake if ready.
  task automatic wait_rsp(input int t, input int lat);
    int waited;
    logic [EW-1:0] exp;
    waited = 0;
    while (!rsp_valid && waited < 100) begin
      step();
      waited++;
    end
    check("rsp_valid", CW'(rsp_valid), CW'(1));
    check("latency", CW'(cyc - t), CW'(lat));
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    check("rsp_fields", CW'({rsp_id, rsp_err, rsp_quotient, rsp_remainder}), CW'(exp));
    if (rsp_ready) step();
  endtask

  function automatic logic [CW-1:0] all_outputs();
    return CW'({rsp_valid, busy, req_ready, rsp_id, rsp_err, rsp_quotient, rsp_remainder});
  endfunction

  initial begin
    int t;
    int rr;
    int g;
    int bad;
    int id;
    int d;
    logic [WIDTH-1:0] x;
    logic [EW-1:0] snap;

    n_vec = 0;
    n_err = 0;
    stall = 1'b1;
    req_valid = '0;
    req_data = '0;
    rsp_ready = 1'b1;
    step();
    step();
    stall = 1'b0;
    check("reset_outputs", all_outputs(), '0);

    // Basic sqrt.
    drive(0, 32'd1000000); wait_grant(0, 1'b0, t); wait_rsp(t, LAT);
    check("rsp_drop", CW'({rsp_valid, busy}), '0);

    // Non-square then zero.
    drive(2, 32'd17); wait_grant(2, 1'b0, t); wait_rsp(t, LAT);
    drive(2, 32'd0);  wait_grant(2, 1'b0, t); wait_rsp(t, LAT);

    // Range boundaries: largest legal operand, smallest and largest illegal.
    drive(1, 32'h3FFF_FFFF); wait_grant(1, 1'b0, t); wait_rsp(t, LAT);
    drive(3, 32'h4000_0000); wait_grant(3, 1'b0, t); wait_rsp(t, 1);
    drive(0, 32'hFFFF_FFFF); wait_grant(0, 1'b0, t); wait_rsp(t, 1);

    // Round-robin fairness from a fresh pointer.
    stall = 1'b1; step(); stall = 1'b0;
    drive(0, 32'd4); drive(1, 32'd9); drive(2, 32'd16); drive(3, 32'd25);
    rr = 0;
    for (int k = 0; k < 5; k++) begin
      g = rr;
      wait_grant(g, k < 4, t);
      if (k == 4) req_valid = '0;
      rr = (g + 1) % NUM_REQ;
      wait_rsp(t, LAT);
    end

    // Backpressure: response held, no accept until after the handshake.
    rsp_ready = 1'b0;
    drive(1, 32'd50); wait_grant(1, 1'b0, t); wait_rsp(t, LAT);
    snap = {rsp_id, rsp_err, rsp_quotient, rsp_remainder};
    drive(2, 32'd81);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!rsp_valid || !busy || req_ready != '0 ||
          {rsp_id, rsp_err, rsp_quotient, rsp_remainder} !== snap) bad++;
    end
    check("bp_stable", CW'(bad), '0);
    rsp_ready = 1'b1;
    step();
    check("bp_handshake_drop", CW'({rsp_valid, busy}), '0);
    check("bp_ready_after", CW'(req_ready), CW'(4'b0100));
    wait_grant(2, 1'b0, t); wait_rsp(t, LAT);

    // Reset in the middle of WAIT drops the job.
    drive(1, 32'd12345); wait_grant(1, 1'b0, t);
    repeat (5) step();
    check("busy_in_wait", CW'(busy), CW'(1));
    stall = 1'b1;
    step();
    check("midreset_outputs", all_outputs(), '0);
    stall = 1'b0;
    exp_q.delete();
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (rsp_valid) bad++;
    end
    check("no_rsp_after_reset", CW'(bad), '0);
    drive(3, 32'd144); wait_grant(3, 1'b0, t); wait_rsp(t, LAT);

    // Random operands, requesters and response delays.
    for (int i = 0; i < 12; i++) begin
      id = $urandom_range(0, NUM_REQ - 1);
      if ($urandom_range(0, 5) == 0) x = $urandom | 32'h4000_0000;
      else                           x = $urandom_range(0, 32'h3FFF_FFFF);
      d = $urandom_range(0, 3);
      rsp_ready = (d == 0);
      drive(id, x);
      wait_grant(id, 1'b0, t);
      wait_rsp(t, (x >= 32'h4000_0000) ? 1 : LAT);
      if (d != 0) begin
        repeat (d) step();
        check("rand_hold", CW'(rsp_valid), CW'(1));
        rsp_ready = 1'b1;
        step();
      end
      check("rand_drop", CW'(rsp_valid), '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
